// File: rtl/ps2_pkg.sv
// Shared constants, state types and helpers for the PS/2 keyboard receiver and
// the Set-2 prefix decoder.
package ps2_pkg;

  localparam logic [7:0] PS2_PFX_EXT   = 8'hE0;
  localparam logic [7:0] PS2_PFX_REL   = 8'hF0;
  localparam logic [7:0] PS2_PFX_PAUSE = 8'hE1;
  localparam int         PS2_PAUSE_LEN = 7;
  localparam int         PS2_SKIP_W    = 3;
  localparam logic [7:0] PS2_PAUSE_KEY = 8'h77;

  localparam int KEY_TOGGLE  = 10;
  localparam int KEY_PRESSED = 9;
  localparam int KEY_EXT     = 8;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_e;

  typedef enum logic {
    DEC_NORMAL,
    DEC_PAUSE
  } dec_state_e;

  // Keyboard self-test, ack, resend, echo and error codes carry no key event.
  function automatic logic is_status_byte(input logic [7:0] b);
    case (b)
      8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF: return 1'b1;
      default:                                  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 frame receiver: input synchronisers, clock glitch filter, 11-bit
// deframer with parity/stop checking and a mid-frame timeout.
module ps2_rx_frame
  import ps2_pkg::*;
#(
  parameter int FILTER  = 4,
  parameter int TIMEOUT = 32768,
  parameter int TW      = 16
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);

  localparam int FW = (FILTER > 1) ? $clog2(FILTER) : 1;

  logic [1:0]    clk_sync, data_sync;
  logic          clk_filt;
  logic [FW-1:0] filt_cnt;
  logic          strobe;
  logic          data_bit;

  assign data_bit = data_sync[1];

  // NOTE: state updates use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would chain the synchroniser stages.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
      clk_filt  <= 1'b1;
      filt_cnt  <= '0;
      strobe    <= 1'b0;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
      strobe    <= 1'b0;
      if (clk_sync[1] == clk_filt) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FW'(FILTER - 1)) begin
        clk_filt <= clk_sync[1];
        filt_cnt <= '0;
        strobe   <= ~clk_sync[1];
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

  rx_state_e     state, state_n;
  logic [2:0]    bit_idx, bit_idx_n;
  logic [7:0]    shreg, shreg_n;
  logic          par_bit, par_bit_n;
  logic [TW-1:0] tmo_cnt, tmo_cnt_n;
  logic [7:0]    rx_byte_n;
  logic          rx_valid_n, parity_err_n, frame_err_n;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state      <= RX_IDLE;
      bit_idx    <= '0;
      shreg      <= '0;
      par_bit    <= 1'b0;
      tmo_cnt    <= '0;
      rx_byte    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_n;
      bit_idx    <= bit_idx_n;
      shreg      <= shreg_n;
      par_bit    <= par_bit_n;
      tmo_cnt    <= tmo_cnt_n;
      rx_byte    <= rx_byte_n;
      rx_valid   <= rx_valid_n;
      parity_err <= parity_err_n;
      frame_err  <= frame_err_n;
    end
  end

  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_n      = state;
    bit_idx_n    = bit_idx;
    shreg_n      = shreg;
    par_bit_n    = par_bit;
    tmo_cnt_n    = '0;
    rx_byte_n    = rx_byte;
    rx_valid_n   = 1'b0;
    parity_err_n = 1'b0;
    frame_err_n  = 1'b0;

    if (state != RX_IDLE && !strobe) tmo_cnt_n = tmo_cnt + 1'b1;

    case (state)
      RX_IDLE: begin
        if (strobe && !data_bit) begin
          state_n   = RX_DATA;
          bit_idx_n = '0;
        end
      end
      RX_DATA: begin
        if (strobe) begin
          shreg_n   = {data_bit, shreg[7:1]};
          bit_idx_n = bit_idx + 1'b1;
          if (bit_idx == 3'd7) state_n = RX_PARITY;
        end
      end
      RX_PARITY: begin
        if (strobe) begin
          par_bit_n = data_bit;
          state_n   = RX_STOP;
        end
      end
      RX_STOP: begin
        if (strobe) begin
          state_n = RX_IDLE;
          if (!data_bit) begin
            frame_err_n = 1'b1;
          end else if (^{shreg, par_bit}) begin
            rx_valid_n = 1'b1;
            rx_byte_n  = shreg;
          end else begin
            parity_err_n = 1'b1;
          end
        end
      end
      default: state_n = RX_IDLE;
    endcase

    // A stalled keyboard must not wedge the receiver mid-frame.
    if (state != RX_IDLE && !strobe && tmo_cnt == TW'(TIMEOUT - 1)) begin
      state_n     = RX_IDLE;
      frame_err_n = 1'b1;
      tmo_cnt_n   = '0;
    end
  end

  assign busy = (state != RX_IDLE);

endmodule

// File: rtl/ps2_kbd_decoder.sv
// PS/2 Set-2 keyboard decoder: folds E0/F0/E1 prefixes from the frame
// receiver into single 11-bit ps2_key events with a toggle bit.
module ps2_kbd_decoder
  import ps2_pkg::*;
#(
  parameter int FILTER  = 4,
  parameter int TIMEOUT = 32768,
  parameter int TW      = 16
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [10:0] ps2_key,
  output logic        key_strobe,
  output logic [7:0]  rx_byte,
  output logic        rx_valid,
  output logic        parity_err,
  output logic        frame_err,
  output logic        busy
);

  ps2_rx_frame #(
    .FILTER (FILTER),
    .TIMEOUT(TIMEOUT),
    .TW     (TW)
  ) u_rx (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .rx_byte   (rx_byte),
    .rx_valid  (rx_valid),
    .parity_err(parity_err),
    .frame_err (frame_err),
    .busy      (busy)
  );

  dec_state_e            state, state_n;
  logic                  ext, ext_n, rel, rel_n;
  logic [PS2_SKIP_W-1:0] skip, skip_n;
  logic [10:0]           key_n;
  logic                  key_strobe_n;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state      <= DEC_NORMAL;
      ext        <= 1'b0;
      rel        <= 1'b0;
      skip       <= '0;
      ps2_key    <= '0;
      key_strobe <= 1'b0;
    end else begin
      state      <= state_n;
      ext        <= ext_n;
      rel        <= rel_n;
      skip       <= skip_n;
      ps2_key    <= key_n;
      key_strobe <= key_strobe_n;
    end
  end

  always_comb begin
    state_n      = state;
    ext_n        = ext;
    rel_n        = rel;
    skip_n       = skip;
    key_n        = ps2_key;
    key_strobe_n = 1'b0;

    if (rx_valid) begin
      case (state)
        DEC_NORMAL: begin
          if (rx_byte == PS2_PFX_EXT) begin
            ext_n = 1'b1;
          end else if (rx_byte == PS2_PFX_REL) begin
            rel_n = 1'b1;
          end else if (rx_byte == PS2_PFX_PAUSE) begin
            state_n = DEC_PAUSE;
            skip_n  = PS2_SKIP_W'(PS2_PAUSE_LEN);
          end else if (ext || rel || !is_status_byte(rx_byte)) begin
            key_n[KEY_TOGGLE]  = ~ps2_key[KEY_TOGGLE];
            key_n[KEY_PRESSED] = ~rel;
            key_n[KEY_EXT]     = ext;
            key_n[7:0]         = rx_byte;
            key_strobe_n       = 1'b1;
            ext_n              = 1'b0;
            rel_n              = 1'b0;
          end
        end
        DEC_PAUSE: begin
          // Pause has no break code; its whole 8-byte burst is one press.
          if (skip == PS2_SKIP_W'(1)) begin
            key_n        = {~ps2_key[KEY_TOGGLE], 1'b1, 1'b1, PS2_PAUSE_KEY};
            key_strobe_n = 1'b1;
            state_n      = DEC_NORMAL;
            skip_n       = '0;
          end else begin
            skip_n = skip - 1'b1;
          end
        end
        default: state_n = DEC_NORMAL;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_kbd_decoder.sv
// Self-checking bench for ps2_kbd_decoder: serialises PS/2 frames and compares
// against a byte-level model of the Set-2 prefix rules.
module tb_ps2_kbd_decoder;

  localparam int FILTER  = 4;
  localparam int TIMEOUT = 32768;
  localparam int TW      = 16;
  localparam int HP      = 20;

  logic        clk_sys  = 1'b0;
  logic        reset    = 1'b1;
  logic        ps2_clk  = 1'b1;
  logic        ps2_data = 1'b1;
  logic [10:0] ps2_key;
  logic        key_strobe;
  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic        parity_err;
  logic        frame_err;
  logic        busy;

  int checks = 0;
  int errors = 0;

  int   n_rx = 0, n_key = 0, n_perr = 0, n_ferr = 0, n_busy = 0, lat_bad = 0;
  logic rx_valid_d = 1'b0;

  logic [10:0] m_key;
  bit          m_ext, m_rel;
  int          m_pause;
  int          m_keys = 0;

  logic [7:0] status_list [6] = '{8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF};

  always #5 clk_sys = ~clk_sys;

  ps2_kbd_decoder #(
    .FILTER (FILTER),
    .TIMEOUT(TIMEOUT),
    .TW     (TW)
  ) dut (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .ps2_key   (ps2_key),
    .key_strobe(key_strobe),
    .rx_byte   (rx_byte),
    .rx_valid  (rx_valid),
    .parity_err(parity_err),
    .frame_err (frame_err),
    .busy      (busy)
  );

  // Event counters sampled on the inactive edge.
  always @(negedge clk_sys) begin
    rx_valid_d <= rx_valid;
    if (rx_valid)   n_rx   <= n_rx + 1;
    if (key_strobe) n_key  <= n_key + 1;
    if (parity_err) n_perr <= n_perr + 1;
    if (frame_err)  n_ferr <= n_ferr + 1;
    if (busy)       n_busy <= n_busy + 1;
    if (key_strobe && !rx_valid_d) lat_bad <= lat_bad + 1;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_sys);
      #1;
    end
  endtask

  task automatic model_reset();
    m_key   = '0;
    m_ext   = 1'b0;
    m_rel   = 1'b0;
    m_pause = 0;
  endtask

  task automatic model_emit(input bit pressed, input bit extended, input logic [7:0] b);
    m_key = {~m_key[10], pressed, extended, b};
    m_keys++;
  endtask

  task automatic model_byte(input logic [7:0] b);
    bit is_status;
    is_status = 1'b0;
    foreach (status_list[i]) if (status_list[i] == b) is_status = 1'b1;
    if (m_pause > 0) begin
      m_pause--;
      if (m_pause == 0) model_emit(1'b1, 1'b1, 8'h77);
    end else if (b == 8'hE0) begin
      m_ext = 1'b1;
    end else if (b == 8'hF0) begin
      m_rel = 1'b1;
    end else if (b == 8'hE1) begin
      m_pause = 7;
    end else if (m_ext || m_rel || !is_status) begin
      model_emit(!m_rel, m_ext, b);
      m_ext = 1'b0;
      m_rel = 1'b0;
    end
  endtask

  task automatic send_bits(input logic [10:0] bits, input int nbits, input int hp);
    for (int i = 0; i < nbits; i++) begin
      ps2_data = bits[i];
      tick(hp);
      ps2_clk = 1'b0;
      tick(hp);
      ps2_clk = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit flip_par, input bit bad_stop,
                            input int hp);
    logic [10:0] bits;
    bits = {~bad_stop, (~^b) ^ flip_par, b, 1'b0};
    send_bits(bits, 11, hp);
    ps2_data = 1'b1;
    tick(hp + 16);
  endtask

  task automatic send_good(input logic [7:0] b, input int hp);
    send_frame(b, 1'b0, 1'b0, hp);
    model_byte(b);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    model_reset();
    tick(5);
    checks++;
    if (ps2_key !== 11'h000) begin
      errors++;
      $display("FAIL reset_ps2_key got %h want 000", ps2_key);
    end
    checks++;
    if (rx_byte !== 8'h00) begin
      errors++;
      $display("FAIL reset_rx_byte got %h want 00", rx_byte);
    end
    checks++;
    if ({key_strobe, rx_valid, parity_err, frame_err, busy} !== 5'b0) begin
      errors++;
      $display("FAIL reset_pulses got %b want 00000",
               {key_strobe, rx_valid, parity_err, frame_err, busy});
    end
    reset = 1'b0;
    tick(10);
  endtask

  task automatic test_clean_frame();
    int r0, k0;
    r0 = n_rx;
    k0 = n_key;
    send_good(8'h1C, 1000);
    checks++;
    if (n_rx - r0 !== 1) begin
      errors++;
      $display("FAIL clean_rx_count got %0d want 1", n_rx - r0);
    end
    checks++;
    if (rx_byte !== 8'h1C) begin
      errors++;
      $display("FAIL clean_rx_byte got %h want 1c", rx_byte);
    end
    checks++;
    if (ps2_key !== 11'h61C) begin
      errors++;
      $display("FAIL clean_ps2_key got %h want 61c", ps2_key);
    end
    checks++;
    if (n_key - k0 !== 1) begin
      errors++;
      $display("FAIL clean_key_count got %0d want 1", n_key - k0);
    end
  endtask

  task automatic test_prefix();
    int   k0;
    logic tog0;
    k0   = n_key;
    tog0 = ps2_key[10];
    send_good(8'hE0, HP);
    send_good(8'hF0, HP);
    checks++;
    if (n_key !== k0) begin
      errors++;
      $display("FAIL prefix_no_strobe got %0d strobes want 0", n_key - k0);
    end
    send_good(8'h75, HP);
    checks++;
    if (ps2_key[9:0] !== 10'h175) begin
      errors++;
      $display("FAIL prefix_key got %h want 175", ps2_key[9:0]);
    end
    checks++;
    if (ps2_key[10] !== ~tog0 || n_key - k0 !== 1) begin
      errors++;
      $display("FAIL prefix_toggle got tog %b strobes %0d want tog %b strobes 1",
               ps2_key[10], n_key - k0, ~tog0);
    end
  endtask

  task automatic test_errors();
    logic [10:0] key0;
    logic [7:0]  byte0;
    int          p0, f0, r0;
    key0  = ps2_key;
    byte0 = rx_byte;
    p0    = n_perr;
    f0    = n_ferr;
    r0    = n_rx;
    send_frame(8'h1C, 1'b1, 1'b0, HP);
    checks++;
    if (n_perr - p0 !== 1 || n_rx !== r0) begin
      errors++;
      $display("FAIL parity_err_pulse got perr %0d rx %0d want perr 1 rx 0",
               n_perr - p0, n_rx - r0);
    end
    checks++;
    if (rx_byte !== byte0 || ps2_key !== key0) begin
      errors++;
      $display("FAIL parity_err_hold got byte %h key %h want byte %h key %h",
               rx_byte, ps2_key, byte0, key0);
    end
    send_frame(8'h1C, 1'b1, 1'b1, HP);
    checks++;
    if (n_ferr - f0 !== 1 || n_perr - p0 !== 1) begin
      errors++;
      $display("FAIL both_err got ferr %0d perr %0d want ferr 1 perr 1(total)",
               n_ferr - f0, n_perr - p0);
    end
    send_good(8'h1B, HP);
    checks++;
    if (ps2_key !== m_key || rx_byte !== 8'h1B) begin
      errors++;
      $display("FAIL after_err_key got key %h byte %h want key %h byte 1b",
               ps2_key, rx_byte, m_key);
    end
  endtask

  task automatic test_timeout();
    int          f0, cyc;
    logic [10:0] bits;
    f0   = n_ferr;
    bits = {2'b11, 8'h29, 1'b0};
    send_bits(bits, 5, HP);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL timeout_busy_mid got %b want 1", busy);
    end
    cyc = HP;
    while (n_ferr == f0 && cyc < 40000) begin
      tick(1);
      cyc++;
    end
    checks++;
    if (n_ferr - f0 !== 1 || cyc < TIMEOUT || cyc > TIMEOUT + 24) begin
      errors++;
      $display("FAIL timeout_frame_err got ferr %0d after %0d cycles want 1 near %0d",
               n_ferr - f0, cyc, TIMEOUT);
    end
    if (cyc < 40000) tick(40000 - cyc);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL timeout_busy_idle got %b want 0", busy);
    end
    send_good(8'h29, HP);
    checks++;
    if (rx_byte !== 8'h29 || ps2_key !== m_key) begin
      errors++;
      $display("FAIL timeout_recover got byte %h key %h want byte 29 key %h",
               rx_byte, ps2_key, m_key);
    end
  endtask

  task automatic test_pause();
    logic [7:0] seq [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    int k0;
    k0 = n_key;
    foreach (seq[i]) send_good(seq[i], HP);
    checks++;
    if (n_key - k0 !== 1) begin
      errors++;
      $display("FAIL pause_strobes got %0d want 1", n_key - k0);
    end
    checks++;
    if (ps2_key[9:0] !== 10'h377 || ps2_key !== m_key) begin
      errors++;
      $display("FAIL pause_key got %h want %h", ps2_key, m_key);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [10:0] bits;
    int          r0, k0;
    bits = {2'b11, 8'h5A, 1'b0};
    send_bits(bits, 6, HP);
    ps2_data = bits[6];
    tick(HP);
    ps2_clk = 1'b0;
    tick(HP / 2);
    reset = 1'b1;
    model_reset();
    tick(3);
    checks++;
    if (busy !== 1'b0 || ps2_key !== 11'h000) begin
      errors++;
      $display("FAIL midreset_state got busy %b key %h want busy 0 key 000", busy, ps2_key);
    end
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    tick(5);
    reset = 1'b0;
    tick(40);
    r0 = n_rx;
    k0 = n_key;
    send_good(8'hAA, HP);
    checks++;
    if (n_rx - r0 !== 1 || rx_byte !== 8'hAA) begin
      errors++;
      $display("FAIL midreset_status_rx got count %0d byte %h want count 1 byte aa",
               n_rx - r0, rx_byte);
    end
    checks++;
    if (n_key !== k0 || ps2_key !== 11'h000) begin
      errors++;
      $display("FAIL midreset_status_key got strobes %0d key %h want 0 key 000",
               n_key - k0, ps2_key);
    end
  endtask

  task automatic test_glitch();
    int r0, f0, b0;
    r0 = n_rx;
    f0 = n_ferr;
    b0 = n_busy;
    ps2_data = 1'b0;
    for (int i = 0; i < 12; i++) begin
      ps2_clk = 1'b0;
      tick(1 + (i % (FILTER - 1)));
      ps2_clk = 1'b1;
      tick(10);
    end
    tick(20);
    ps2_data = 1'b1;
    tick(5);
    checks++;
    if (n_busy !== b0 || n_rx !== r0 || n_ferr !== f0) begin
      errors++;
      $display("FAIL glitch_no_strobe got busy %0d rx %0d ferr %0d want 0 0 0",
               n_busy - b0, n_rx - r0, n_ferr - f0);
    end
  endtask

  task automatic test_random();
    logic [7:0] exp_raw;
    exp_raw = rx_byte;
    for (int i = 0; i < 16; i++) begin
      logic [7:0] b;
      int         sel, hp, k0, mk0;
      bit         bad;
      sel = $urandom_range(0, 9);
      hp  = $urandom_range(12, 24);
      bad = ($urandom_range(0, 7) == 0);
      case (sel)
        0:       b = 8'hE0;
        1:       b = 8'hF0;
        2:       b = status_list[$urandom_range(0, 5)];
        default: b = 8'($urandom_range(0, 255));
      endcase
      if (b == 8'hE1) b = 8'hE2;
      k0  = n_key;
      mk0 = m_keys;
      if (bad) begin
        send_frame(b, 1'b1, 1'b0, hp);
      end else begin
        send_good(b, hp);
        exp_raw = b;
      end
      checks++;
      if (ps2_key !== m_key || rx_byte !== exp_raw || n_key - k0 !== m_keys - mk0) begin
        errors++;
        $display("FAIL random_%0d byte %h bad %0d got key %h raw %h strobes %0d want key %h raw %h strobes %0d",
                 i, b, bad, ps2_key, rx_byte, n_key - k0, m_key, exp_raw, m_keys - mk0);
      end
    end
  endtask

  task automatic test_latency();
    checks++;
    if (lat_bad !== 0) begin
      errors++;
      $display("FAIL key_strobe_latency got %0d strobes not one cycle after rx_valid want 0",
               lat_bad);
    end
  endtask

  initial begin
    test_reset();
    test_clean_frame();
    test_prefix();
    test_errors();
    test_timeout();
    test_pause();
    test_reset_mid_frame();
    test_glitch();
    test_random();
    test_latency();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
